prince_sbox_cms_seq: RTL and testbench



---
 rtl/prince_cms_pkg.sv | 17 +
 rtl/prince_sbox_cms_seq_if.sv | 46 ++++
 rtl/prince_sbox_cms_track.sv | 41 ++++
 rtl/prince_sbox_cms_seq.sv | 119 +++++++++++
 tb/tb_prince_sbox_cms_seq.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/prince_cms_pkg.sv
// Shared definitions for the CMS-masked PRINCE sequencers.
//   seq_state_t    : S-box layer sequencer FSM states
//   PRINCE_NIBBLES : nibble positions in the 64-bit PRINCE state
//   CMS_SBOX_LAT   : register stages in the shared masked S-box core
package prince_cms_pkg;

    localparam int unsigned PRINCE_NIBBLES = 16;
    localparam int unsigned CMS_SBOX_LAT   = 2;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } seq_state_t;

endpackage

// File: rtl/prince_sbox_cms_seq_if.sv
// Handshake bundle between the round controller / S-box datapath and the
// S-box layer sequencer.
//   master : round controller side (drives start, rnd_valid, optional inv)
//   slave  : sequencer side (drives busy, done, rnd_ready, issue, write-back)
// Optional macro PRINCE_SBOX_SEQ_INV_EN adds inv / sbox_inv.
interface prince_sbox_cms_seq_if
    import prince_cms_pkg::*;
#(
    parameter int unsigned IDX_W = $clog2(PRINCE_NIBBLES)
) ();

    logic             start;
    logic             busy;
    logic             done;
    logic             rnd_valid;
    logic             rnd_ready;
    logic             issue;
    logic [IDX_W-1:0] issue_idx;
    logic             wb_en;
    logic [IDX_W-1:0] wb_idx;
`ifdef PRINCE_SBOX_SEQ_INV_EN
    logic             inv;
    logic             sbox_inv;

    modport master (
        output start, rnd_valid, inv,
        input  busy, done, rnd_ready, issue, issue_idx, wb_en, wb_idx, sbox_inv
    );

    modport slave (
        input  start, rnd_valid, inv,
        output busy, done, rnd_ready, issue, issue_idx, wb_en, wb_idx, sbox_inv
    );
`else
    modport master (
        output start, rnd_valid,
        input  busy, done, rnd_ready, issue, issue_idx, wb_en, wb_idx
    );

    modport slave (
        input  start, rnd_valid,
        output busy, done, rnd_ready, issue, issue_idx, wb_en, wb_idx
    );
`endif

endinterface

// File: rtl/prince_sbox_cms_track.sv
// LAT-deep valid + index delay line that mirrors the register stages of a
// pipelined masked core, so a result can be routed back to its source slot.
//   clk, rst_n          : clock, asynchronous active-low clear
//   in_valid, in_idx    : item entering the core this cycle
//   out_valid, out_idx  : item leaving the core (registered)
module prince_sbox_cms_track #(
    parameter int unsigned LAT   = 2,
    parameter int unsigned IDX_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [IDX_W-1:0] in_idx,
    output logic             out_valid,
    output logic [IDX_W-1:0] out_idx
);

    logic [LAT-1:0]   valid_q;
    logic [IDX_W-1:0] idx_q [LAT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int i = 0; i < int'(LAT); i++) begin
                idx_q[i] <= '0;
            end
        end else begin
            valid_q[0] <= in_valid;
            // Bubbles carry index 0 so the popped index is quiet when invalid.
            idx_q[0]   <= in_valid ? in_idx : '0;
            for (int i = 1; i < int'(LAT); i++) begin
                valid_q[i] <= valid_q[i-1];
                idx_q[i]   <= idx_q[i-1];
            end
        end
    end

    assign out_valid = valid_q[LAT-1];
    assign out_idx   = idx_q[LAT-1];

endmodule

// File: rtl/prince_sbox_cms_seq.sv
// Sequencer for the shared pipelined CMS-masked PRINCE S-box core. Walks all
// NIBBLES state positions, issuing one per cycle whenever fresh randomness is
// available, and produces the write-back strobe/index LAT cycles later.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of prince_sbox_cms_seq_if
//                (start/busy/done, rnd_valid/rnd_ready, issue/issue_idx,
//                 wb_en/wb_idx; inv/sbox_inv with PRINCE_SBOX_SEQ_INV_EN)
// Optional macro PRINCE_SBOX_SEQ_INV_EN: latch inv at start, drive sbox_inv
// for the whole layer to select the inverse S-box.
module prince_sbox_cms_seq
    import prince_cms_pkg::*;
#(
    parameter int unsigned NIBBLES = PRINCE_NIBBLES,
    parameter int unsigned LAT     = CMS_SBOX_LAT,
    parameter int unsigned IDX_W   = $clog2(NIBBLES)
) (
    input logic                 clk,
    input logic                 rst_n,
    prince_sbox_cms_seq_if.slave bus
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    seq_state_t       state_q;
    logic [IDX_W-1:0] issue_cnt_q;
    logic [IDX_W-1:0] wb_cnt_q;
    logic             busy_q;
    logic             done_q;
    logic             issue;
    logic             wb_en;
    logic [IDX_W-1:0] wb_idx;
`ifdef PRINCE_SBOX_SEQ_INV_EN
    logic             sbox_inv_q;
`endif

    // The core is never stalled: missing randomness just leaves a bubble.
    assign issue = (state_q == ISSUE) && bus.rnd_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            issue_cnt_q <= '0;
            wb_cnt_q    <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef PRINCE_SBOX_SEQ_INV_EN
            sbox_inv_q  <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        state_q     <= ISSUE;
                        busy_q      <= 1'b1;
                        issue_cnt_q <= '0;
                        wb_cnt_q    <= '0;
`ifdef PRINCE_SBOX_SEQ_INV_EN
                        sbox_inv_q  <= bus.inv;
`endif
                    end
                end
                ISSUE: begin
                    if (issue) begin
                        // Wraps to 0 on the last nibble, leaving issue_idx clean.
                        issue_cnt_q <= issue_cnt_q + 1'b1;
                        if (issue_cnt_q == LAST_IDX) begin
                            state_q <= DRAIN;
                        end
                    end
                    // Early results retire while later nibbles are still issuing.
                    if (wb_en) begin
                        wb_cnt_q <= wb_cnt_q + 1'b1;
                    end
                end
                DRAIN: begin
                    if (wb_en) begin
                        wb_cnt_q <= wb_cnt_q + 1'b1;
                        if (wb_cnt_q == LAST_IDX) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_q    <= IDLE;
                    busy_q     <= 1'b0;
`ifdef PRINCE_SBOX_SEQ_INV_EN
                    sbox_inv_q <= 1'b0;
`endif
                end
            endcase
        end
    end

    prince_sbox_cms_track #(
        .LAT   (LAT),
        .IDX_W (IDX_W)
    ) u_track (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (issue),
        .in_idx    (issue_cnt_q),
        .out_valid (wb_en),
        .out_idx   (wb_idx)
    );

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.issue     = issue;
    assign bus.rnd_ready = issue;
    assign bus.issue_idx = (state_q == ISSUE) ? issue_cnt_q : '0;
    assign bus.wb_en     = wb_en;
    assign bus.wb_idx    = wb_idx;
`ifdef PRINCE_SBOX_SEQ_INV_EN
    assign bus.sbox_inv  = sbox_inv_q;
`endif

endmodule

// File: tb/tb_prince_sbox_cms_seq.sv
// Scoreboard bench for prince_sbox_cms_seq. Each layer's randomness pattern
// is turned into expected issue / write-back / done events by a cycle-level
// model; a negedge monitor pops and compares them against the DUT.
module tb_prince_sbox_cms_seq;
    import prince_cms_pkg::*;

    localparam int N = PRINCE_NIBBLES;
    localparam int L = CMS_SBOX_LAT;
    localparam int W = 4;

    typedef struct {
        int cyc;
        int idx;
    } ev_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    ev_t  exp_iss[$];
    ev_t  exp_wb[$];
    int   exp_done[$];
    bit   pat[$];
    int   busy_lo = 1;
    int   busy_hi = 0;
    bit   exp_inv = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    prince_sbox_cms_seq_if #(.IDX_W(W)) bus ();

    prince_sbox_cms_seq #(
        .NIBBLES (N),
        .LAT     (L),
        .IDX_W   (W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%0d expected=%0d", name, cyc, act, exp);
        end
    endtask

    function automatic bit rv_at(input int i);
        if (i < pat.size()) return pat[i];
        return 1'b1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ctrl"}, int'({bus.busy, bus.done, bus.rnd_ready, bus.issue, bus.wb_en}), 0);
        check({tag, "_issue_idx"}, int'(bus.issue_idx), 0);
        check({tag, "_wb_idx"}, int'(bus.wb_idx), 0);
`ifdef PRINCE_SBOX_SEQ_INV_EN
        check({tag, "_sbox_inv"}, int'(bus.sbox_inv), 0);
`endif
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            tick();
            bus.start     = 1'b0;
            bus.rnd_valid = 1'($urandom_range(0, 1));
        end
    endtask

    // Starts a layer in the next cycle. extra_rel: re-pulse start that many
    // cycles after the start cycle; abort_rel: assert reset in that cycle.
    task automatic run_layer(input int extra_rel, input bit start_at_done,
                             input int abort_rel, input bit inv_val);
        int s, t, k, t_last, done_c, limit;
        tick();
        s = cyc;
        bus.start     = 1'b1;
        bus.rnd_valid = 1'($urandom_range(0, 1));
`ifdef PRINCE_SBOX_SEQ_INV_EN
        bus.inv = inv_val;
`endif
        limit  = (abort_rel >= 0) ? s + abort_rel : 32'h7fff_ffff;
        t      = s + 1;
        k      = 0;
        t_last = s;
        // Nibble k enters the core on the k-th randomness cycle after start.
        while (k < N) begin
            if (rv_at(t - s - 1)) begin
                if (t < limit) exp_iss.push_back('{cyc: t, idx: k});
                if (t + L < limit) exp_wb.push_back('{cyc: t + L, idx: k});
                t_last = t;
                k++;
            end
            t++;
        end
        done_c = t_last + L + 1;
        if (done_c < limit) exp_done.push_back(done_c);
        busy_lo = s + 1;
        busy_hi = (done_c < limit) ? done_c : limit - 1;
        exp_inv = inv_val;
        for (int c = s + 1; c <= done_c; c++) begin
            tick();
            bus.start     = ((c - s) == extra_rel);
            bus.rnd_valid = rv_at(c - s - 1);
`ifdef PRINCE_SBOX_SEQ_INV_EN
            if (c - s == 5) bus.inv = ~bus.inv;
`endif
            if (c == limit) begin
                #1 rst_n = 1'b0;
                #1 check_reset_outputs("abort_reset");
                bus.start = 1'b0;
                tick();
                tick();
                rst_n = 1'b1;
                return;
            end
            if (c == done_c) bus.start = start_at_done;
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin : mon
            bit  e;
            bit  in_win;
            ev_t ev;

            while (exp_iss.size() > 0 && exp_iss[0].cyc < cyc) void'(exp_iss.pop_front());
            e = (exp_iss.size() > 0 && exp_iss[0].cyc == cyc);
            check("issue", int'(bus.issue), int'(e));
            check("rnd_ready", int'(bus.rnd_ready), int'(e));
            if (e) begin
                ev = exp_iss.pop_front();
                if (bus.issue) check("issue_idx", int'(bus.issue_idx), ev.idx);
            end

            while (exp_wb.size() > 0 && exp_wb[0].cyc < cyc) void'(exp_wb.pop_front());
            e = (exp_wb.size() > 0 && exp_wb[0].cyc == cyc);
            check("wb_en", int'(bus.wb_en), int'(e));
            if (e) begin
                ev = exp_wb.pop_front();
                if (bus.wb_en) check("wb_idx", int'(bus.wb_idx), ev.idx);
            end

            while (exp_done.size() > 0 && exp_done[0] < cyc) void'(exp_done.pop_front());
            e = (exp_done.size() > 0 && exp_done[0] == cyc);
            check("done", int'(bus.done), int'(e));
            if (e) void'(exp_done.pop_front());

            in_win = (cyc >= busy_lo && cyc <= busy_hi);
            check("busy", int'(bus.busy), int'(in_win));
`ifdef PRINCE_SBOX_SEQ_INV_EN
            if (in_win) check("sbox_inv", int'(bus.sbox_inv), int'(exp_inv));
`endif
        end
    end

    initial begin
        bus.start     = 1'b0;
        bus.rnd_valid = 1'b0;
`ifdef PRINCE_SBOX_SEQ_INV_EN
        bus.inv       = 1'b0;
`endif
        rst_n = 1'b0;
        #2 check_reset_outputs("init_reset");
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(3);

        // Randomness always available; inv=1 then toggled mid-layer.
        pat.delete();
        run_layer(-1, 1'b0, -1, 1'b1);
        idle(3);

        // Two-cycle bubbles at issue counter values 5 and 11; inv=0.
        pat = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0,
                1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        run_layer(-1, 1'b0, -1, 1'b0);
        idle(2);

        // Stray starts at cycle 7 and at the done cycle, then back-to-back layer.
        pat.delete();
        run_layer(7, 1'b1, -1, 1'b0);
        run_layer(-1, 1'b0, -1, 1'b1);
        idle(3);

        // Reset in cycle 10 of a layer; nothing may follow until a new start.
        run_layer(-1, 1'b0, 10, 1'b1);
        idle(20);
        run_layer(-1, 1'b0, -1, 1'b0);
        idle(2);

        // Randomness starved for 50 cycles.
        pat.delete();
        repeat (50) pat.push_back(1'b0);
        run_layer(-1, 1'b0, -1, 1'b1);
        idle(2);

        // Random availability patterns with random idle gaps (possibly none).
        for (int n = 0; n < 8; n++) begin
            pat.delete();
            repeat (40) pat.push_back($urandom_range(0, 3) != 0);
            run_layer(-1, 1'b0, -1, 1'($urandom_range(0, 1)));
            idle(int'($urandom_range(0, 4)));
        end

        idle(5);
        check("pending_issue", exp_iss.size(), 0);
        check("pending_wb", exp_wb.size(), 0);
        check("pending_done", exp_done.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
